// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial operand feeder.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right register; bit 0 is the serial output.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] q;

    // Load wins over shift so a back-to-back reload never loses the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= din;
        else if (en)
            q <= {1'b0, q[WIDTH-1:1]};
    end

    assign dout = q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Serialises operand pairs LSB first into a downstream bit-serial datapath,
// with first/last framing, a freeze input and zero-gap back-to-back frames.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             hold,
    output logic             a,
    output logic             b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load, shift_en;
    logic            a_bit, b_bit;
    logic            cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift_en = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    shift_en = 1'b1;
                    if (cnt_last) begin
                        // Final bit: reload in place or fall back to idle.
                        in_ready = 1'b1;
                        cnt_d    = '0;
                        if (in_valid)
                            load = 1'b1;
                        else
                            state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (shift_en),
        .din   (in_a),
        .dout  (a_bit)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .en    (shift_en),
        .din   (in_b),
        .dout  (b_bit)
    );

    assign out_valid = (state_q == SHIFT);
    assign a         = out_valid & a_bit;
    assign b         = out_valid & b_bit;
    assign out_first = out_valid & (cnt_q == '0);
    assign out_last  = out_valid & cnt_last;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder at WIDTH=8.
module tb_serial_operand_feeder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         hold;
    logic         a;
    logic         b;
    logic         out_valid;
    logic         out_first;
    logic         out_last;

    logic [5:0]   obs;
    int           n_cmp;
    int           n_err;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .hold      (hold),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last)
    );

    // {in_ready, out_valid, out_first, out_last, a, b}
    assign obs = {in_ready, out_valid, out_first, out_last, a, b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        hold     = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", obs, 6'b100000);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL idle_after_release got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    // 0x81 / 0x04: a=1,0,0,0,0,0,0,1  b=0,0,1,0,0,0,0,0
    task automatic test_single_frame();
        logic [W-1:0] av, bv;
        logic [5:0]   exp;
        av = 8'h81;
        bv = 8'h04;
        in_a = av; in_b = bv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            exp = {(i == W-1), 1'b1, (i == 0), (i == W-1), av[i], bv[i]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL single_frame bit=%0d got=%b exp=%b", i, obs, exp);
            end
            step();
        end
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL single_idle_c9 got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    // (0xFF,0x01) then (0x0F,0xF0) with no gap cycle
    task automatic test_back_to_back();
        logic [W-1:0] a0, b0, a1, b1;
        logic [5:0]   exp;
        int           j;
        a0 = 8'hFF; b0 = 8'h01; a1 = 8'h0F; b1 = 8'hF0;
        in_a = a0; in_b = b0; in_valid = 1'b1;
        step();
        in_a = a1; in_b = b1;
        for (int i = 0; i < 2*W; i++) begin
            j = i % W;
            if (i < W)
                exp = {(j == W-1), 1'b1, (j == 0), (j == W-1), a0[j], b0[j]};
            else
                exp = {(j == W-1), 1'b1, (j == 0), (j == W-1), a1[j], b1[j]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i + 1, obs, exp);
            end
            if (i == W) in_valid = 1'b0;
            step();
        end
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL b2b_idle got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    // 0xA5 / 0x3C, hold during the three cycles after bit 4 first appears
    task automatic test_hold();
        logic [W-1:0] av, bv;
        logic [5:0]   exp;
        int           j;
        av = 8'hA5; bv = 8'h3C;
        in_a = av; in_b = bv; in_valid = 1'b1; hold = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_in_idle in_ready got=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            j = (c < 4) ? c : ((c < 8) ? 4 : c - 3);
            hold = (c >= 4 && c <= 6);
            #1;
            exp = {(j == W-1) && !hold, 1'b1, (j == 0), (j == W-1), av[j], bv[j]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL hold_frame cyc=%0d got=%b exp=%b", c + 1, obs, exp);
            end
            step();
        end
        hold = 1'b0;
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL hold_idle_c12 got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    task automatic test_reset_mid_frame();
        in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (obs !== 6'b010011) begin
            n_err++;
            $display("FAIL pre_reset_bit3 got=%b exp=%b", obs, 6'b010011);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL async_reset got=%b exp=%b", obs, 6'b100000);
        end
        step();
        #1 rst_n = 1'b1;
        in_a = 8'h81; in_b = 8'h04; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (obs !== 6'b011010) begin
            n_err++;
            $display("FAIL accept_after_reset got=%b exp=%b", obs, 6'b011010);
        end
        repeat (W) step();
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL post_reset_idle got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    // New pair offered from bit 2 onward must wait for the out_last cycle.
    task automatic test_ignore_mid_frame();
        logic [W-1:0] a0, b0, a1, b1;
        logic [5:0]   exp;
        int           j;
        a0 = 8'h81; b0 = 8'h04; a1 = 8'h55; b1 = 8'hAA;
        in_a = a0; in_b = b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2*W; i++) begin
            j = i % W;
            if (i == 2) begin
                in_a = a1; in_b = b1; in_valid = 1'b1;
            end
            if (i == W) in_valid = 1'b0;
            #1;
            if (i < W)
                exp = {(j == W-1), 1'b1, (j == 0), (j == W-1), a0[j], b0[j]};
            else
                exp = {(j == W-1), 1'b1, (j == 0), (j == W-1), a1[j], b1[j]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL ignore_mid cyc=%0d got=%b exp=%b", i + 1, obs, exp);
            end
            step();
        end
        n_cmp++;
        if (obs !== 6'b100000) begin
            n_err++;
            $display("FAIL ignore_idle got=%b exp=%b", obs, 6'b100000);
        end
    endtask

    // Bit-serial adder downstream: carry cleared on out_first.
    task automatic test_serial_add();
        logic [W-1:0] sum;
        logic         cy;
        int           j;
        sum = '0; cy = 1'b0; j = 0;
        in_a = 8'h49; in_b = 8'h2A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (out_valid) begin
                if (out_first) begin
                    cy = 1'b0;
                    j  = 0;
                end
                sum[j] = a ^ b ^ cy;
                cy     = (a & b) | (cy & (a ^ b));
                j++;
            end
            step();
        end
        n_cmp++;
        if (sum !== 8'h73 || j != W) begin
            n_err++;
            $display("FAIL serial_add sum got=%h bits=%0d exp=73 bits=%0d", sum, j, W);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold();
        test_reset_mid_frame();
        test_ignore_mid_frame();
        test_serial_add();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
